// File: rtl/ifmap_loader.sv
// ifmap_loader: accepts a valid/ready pixel stream and scatters it across
// INPUT_NUM_MEM feature RAM banks, one full feature map per bank, in
// map-major order. Every accepted pixel becomes a one-cycle port-A write
// pulse on the following cycle.
module ifmap_loader #(
   parameter int DATA_WIDTH       = 16,
   parameter int INPUT_NUM_MEM    = 4,
   parameter int IN_FEATURE_WIDTH = 16,
   parameter int ADDR_WIDTH       = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     in_ready,
   output logic [INPUT_NUM_MEM-1:0] in_feature_wren_a_all,
   output logic [ADDR_WIDTH-1:0]    in_feature_address_a,
   output logic [DATA_WIDTH-1:0]    in_feature_data_a,
   output logic                     busy,
   output logic                     load_done
);

   localparam int NPIX   = IN_FEATURE_WIDTH * IN_FEATURE_WIDTH;
   localparam int BANK_W = (INPUT_NUM_MEM > 1) ? $clog2(INPUT_NUM_MEM) : 1;

   localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(NPIX - 1);
   localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(INPUT_NUM_MEM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]      pix_cnt_q, pix_cnt_d;
   logic [BANK_W-1:0]          bank_cnt_q, bank_cnt_d;
   logic [INPUT_NUM_MEM-1:0]   wren_q, wren_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      data_q, data_d;
   logic                       load_done_q, load_done_d;
   logic                       xfer;

   // Next-state logic: FSM transitions, pixel/bank counting and write capture.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      bank_cnt_d  = bank_cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wren_d      = '0;
      load_done_d = 1'b0;
      xfer        = in_valid && (state_q == LOAD);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD;
               pix_cnt_d  = '0;
               bank_cnt_d = '0;
            end
         end
         LOAD: begin
            // start is deliberately ignored while a load is in progress
            if (xfer) begin
               if (pix_cnt_q == LAST_PIX) begin
                  pix_cnt_d = '0;
                  if (bank_cnt_q == LAST_BANK) begin
                     state_d = DONE;
                  end else begin
                     bank_cnt_d = bank_cnt_q + 1'b1;
                  end
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            // load_done holds until a new start, which clears it on the same edge
            load_done_d = !start;
            if (start) begin
               state_d    = LOAD;
               pix_cnt_d  = '0;
               bank_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // The write is launched from the counters as they stood at the transfer edge.
      for (int k = 0; k < INPUT_NUM_MEM; k++) begin
         wren_d[k] = xfer && (bank_cnt_q == BANK_W'(k));
      end
      if (xfer) begin
         addr_d = pix_cnt_q;
         data_d = in_data;
      end
   end

   // State and output registers; reset also kills any write pulse launched on the prior edge.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: all registers here are control/pipeline flops, so every one is
      // reset; non-blocking assignments keep the update order-independent.
      if (!reset_n) begin
         state_q     <= IDLE;
         pix_cnt_q   <= '0;
         bank_cnt_q  <= '0;
         wren_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         bank_cnt_q  <= bank_cnt_d;
         wren_q      <= wren_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         load_done_q <= load_done_d;
      end
   end

   assign in_ready              = (state_q == LOAD);
   assign busy                  = (state_q == LOAD);
   assign load_done             = load_done_q;
   assign in_feature_wren_a_all = wren_q;
   assign in_feature_address_a  = addr_q;
   assign in_feature_data_a     = data_q;

endmodule

// File: tb/tb_ifmap_loader.sv
// Testbench for ifmap_loader: a fixed vector table for the first full load,
// hand-written corner sequences, then random traffic, all compared against
// a transfer-count based reference model.
module tb_ifmap_loader;

   localparam int DW    = 16;
   localparam int NMEM  = 2;
   localparam int IFW   = 2;
   localparam int AW    = 4;
   localparam int NPIX  = IFW * IFW;
   localparam int TOTAL = NMEM * NPIX;

   logic            clock;
   logic            reset_n;
   logic            start;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_ready;
   logic [NMEM-1:0] wren;
   logic [AW-1:0]   address;
   logic [DW-1:0]   wdata;
   logic            busy;
   logic            load_done;

   ifmap_loader #(
      .DATA_WIDTH      (DW),
      .INPUT_NUM_MEM   (NMEM),
      .IN_FEATURE_WIDTH(IFW),
      .ADDR_WIDTH      (AW)
   ) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .start                (start),
      .in_valid             (in_valid),
      .in_data              (in_data),
      .in_ready             (in_ready),
      .in_feature_wren_a_all(wren),
      .in_feature_address_a (address),
      .in_feature_data_a    (wdata),
      .busy                 (busy),
      .load_done            (load_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0=idle, 1=loading, 2=finished; cnt = pixels accepted so far.
   int              m_phase;
   int              m_cnt;
   logic [NMEM-1:0] m_wren;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_data;
   logic            m_done;

   typedef struct {
      logic            st;
      logic            vld;
      logic [DW-1:0]   dat;
      logic [NMEM-1:0] wren;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic            rdy;
      logic            done;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cnt   = 0;
      m_wren  = '0;
      m_addr  = '0;
      m_data  = '0;
      m_done  = 1'b0;
   endtask

   // Advance the model across one rising edge with the given inputs.
   task automatic model_edge(input logic st, input logic vld, input logic [DW-1:0] dat);
      int old_phase;
      old_phase = m_phase;
      m_wren    = '0;
      if (old_phase == 1 && vld) begin
         m_wren[m_cnt / NPIX] = 1'b1;
         m_addr = AW'(m_cnt % NPIX);
         m_data = dat;
         m_cnt++;
         if (m_cnt == TOTAL) m_phase = 2;
      end
      m_done = (old_phase == 2) && !st;
      if ((old_phase == 0 || old_phase == 2) && st) begin
         m_phase = 1;
         m_cnt   = 0;
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'(m_phase == 1));
      check({tag, ".busy"},      32'(busy),      32'(m_phase == 1));
      check({tag, ".load_done"}, 32'(load_done), 32'(m_done));
      check({tag, ".wren"},      32'(wren),      32'(m_wren));
      check({tag, ".address"},   32'(address),   32'(m_addr));
      check({tag, ".data"},      32'(wdata),     32'(m_data));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'd0);
      check({tag, ".busy"},      32'(busy),      32'd0);
      check({tag, ".load_done"}, 32'(load_done), 32'd0);
      check({tag, ".wren"},      32'(wren),      32'd0);
      check({tag, ".address"},   32'(address),   32'd0);
      check({tag, ".data"},      32'(wdata),     32'd0);
   endtask

   // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
   task automatic step(input logic st, input logic vld, input logic [DW-1:0] dat, input string tag);
      start    = st;
      in_valid = vld;
      in_data  = dat;
      @(posedge clock);
      model_edge(st, vld, dat);
      @(negedge clock);
      compare_model(tag);
   endtask

   // Called at a falling edge: assert reset mid-cycle, hold across an edge, release.
   task automatic mid_reset(input string tag);
      reset_n = 1'b0;
      #1;
      check_zero({tag, ".async"});
      model_reset();
      start    = 1'b1;
      in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_zero({tag, ".held"});
      reset_n  = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 16'd0, 2'b00, 4'd0, 16'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 16'd1, 2'b01, 4'd0, 16'd1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 16'd2, 2'b01, 4'd1, 16'd2, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 16'd3, 2'b01, 4'd2, 16'd3, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 16'd4, 2'b01, 4'd3, 16'd4, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 16'd5, 2'b10, 4'd0, 16'd5, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 16'd6, 2'b10, 4'd1, 16'd6, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 16'd7, 2'b10, 4'd2, 16'd7, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'd8, 2'b10, 4'd3, 16'd8, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 16'd9, 2'b00, 4'd3, 16'd8, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 16'd0, 2'b00, 4'd3, 16'd8, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 16'd0, 2'b00, 4'd3, 16'd8, 1'b1, 1'b0};

      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      model_reset();
      #1;
      check_zero("por");
      @(negedge clock);
      check_zero("por_edge");
      reset_n = 1'b1;

      // Nothing happens after reset release until start, even with valid data.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'hA0 + i), "idle_valid");

      // Full load 1..8 with valid held high, then a restart from DONE.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].st, vecs[i].vld, vecs[i].dat, "vec_model");
         check($sformatf("vec%0d.wren", i),  32'(wren),      32'(vecs[i].wren));
         check($sformatf("vec%0d.addr", i),  32'(address),   32'(vecs[i].addr));
         check($sformatf("vec%0d.data", i),  32'(wdata),     32'(vecs[i].data));
         check($sformatf("vec%0d.rdy", i),   32'(in_ready),  32'(vecs[i].rdy));
         check($sformatf("vec%0d.busy", i),  32'(busy),      32'(vecs[i].rdy));
         check($sformatf("vec%0d.done", i),  32'(load_done), 32'(vecs[i].done));
      end

      // Toggled valid: writes only follow valid cycles, addresses stay contiguous.
      for (int i = 0; i < 2 * TOTAL; i++) step(1'b0, (i % 2) == 0, DW'(16'h100 + i), "toggle");
      check("toggle.count", 32'(m_cnt), 32'(TOTAL));

      // Valid high while in DONE is not accepted.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'h200 + i), "done_valid");

      // start during LOAD after 3 pixels changes nothing.
      step(1'b1, 1'b0, '0, "restart");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'h300 + i), "pre_start");
      step(1'b1, 1'b1, 16'h303, "start_in_load");
      check("start_in_load.addr", 32'(address), 32'd3);
      check("start_in_load.wren", 32'(wren), 32'b01);
      for (int i = 4; i < TOTAL; i++) step(1'b0, 1'b1, DW'(16'h300 + i), "post_start");
      step(1'b0, 1'b0, '0, "post_start_done");

      // Reset after 5 transfers with a write pulse pending, then a clean reload.
      step(1'b1, 1'b0, '0, "rst_load");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(16'h400 + i), "rst_pre");
      mid_reset("mid_reset");
      step(1'b0, 1'b1, 16'h4FF, "rst_idle");
      step(1'b1, 1'b0, '0, "rst_start");
      for (int i = 0; i < TOTAL; i++) begin
         step(1'b0, 1'b1, DW'(16'h500 + i), "reload");
         if (i == 0) check("reload.first_addr", 32'(address), 32'd0);
         if (i == 0) check("reload.first_wren", 32'(wren), 32'b01);
         if (i == TOTAL - 1) check("reload.done_early", 32'(load_done), 32'd0);
      end
      step(1'b0, 1'b0, '0, "reload_done");
      check("reload.done", 32'(load_done), 32'd1);

      // Random traffic with occasional restarts and resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            mid_reset("rand_reset");
         end else begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
                 DW'($urandom), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
